uart_tx_arbiter: RTL

//  Shares one UART byte transmitter between NUM_REQ packet sources (string generators, status reporters).

---
 rtl/uart_tx_arbiter_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM encoding, byte width and
// the latched byte/last pair handed to the UART core.
package uart_tx_arbiter_pkg;

  localparam int UART_BYTE_W = 8;

  typedef logic [UART_BYTE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_e;

  typedef struct packed {
    byte_t data;
    logic  last;
  } tx_byte_t;

  // Next round-robin slot after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and UART-core handshake bundle. The arbiter takes the slave
// view; the sources/UART core (or a bench standing in for them) take master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import uart_tx_arbiter_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  byte_t [NUM_REQ-1:0]        req_data;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         grant;
  byte_t                      tx_data;
  logic                       tx_start;
  logic                       tx_busy;
  logic                       tx_done;
  logic                       abort;

  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, grant, tx_data, tx_start, abort
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, grant, tx_data, tx_start, abort
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping around. Kept generic so other shared-resource blocks can reuse it.
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_oh_o,
  output logic [PW-1:0] win_idx_o,
  output logic          win_any_o
);

  function automatic logic [PW-1:0] slot(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    win_any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!win_any_o && req_i[slot(ptr_i, k)]) begin
        win_any_o              = 1'b1;
        win_idx_o              = slot(ptr_i, k);
        win_oh_o[slot(ptr_i, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART byte transmitter between
// NUM_REQ sources, with owner stall timeout and an idle gap between packets.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  arb_state_e         state_q,   state_d;
  logic [NUM_REQ-1:0] grant_q,   grant_d;
  logic [NUM_REQ-1:0] ready_q,   ready_d;
  logic [PW-1:0]      owner_q,   owner_d;
  logic [PW-1:0]      rr_ptr_q,  rr_ptr_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  tx_byte_t           txb_q,     txb_d;
  logic               abort_q,   abort_d;
  logic               tx_start_c;

  logic [NUM_REQ-1:0] win_oh;
  logic [PW-1:0]      win_idx;
  logic               win_any;
  logic               accept;

  uart_rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .win_any_o (win_any)
  );

  // ready_q is only ever nonzero for the owner while fetching
  assign accept = |(bus.req_valid & ready_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ready_d    = '0;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    txb_d      = txb_q;
    abort_d    = 1'b0;
    tx_start_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d   = ST_FETCH;
          grant_d   = win_oh;
          owner_d   = win_idx;
          ready_d   = win_oh;
          tmo_cnt_d = '0;
        end
      end

      ST_FETCH: begin
        if (accept) begin
          txb_d.data = bus.req_data[owner_q];
          txb_d.last = bus.req_last[owner_q];
          tmo_cnt_d  = '0;
          state_d    = ST_START;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          abort_d   = 1'b1;
          state_d   = ST_GAP;
          grant_d   = '0;
          gap_cnt_d = '0;
          rr_ptr_d  = PW'(rr_next(int'(owner_q), NUM_REQ));
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          ready_d   = grant_q;
        end
      end

      // Launch is decoded from tx_busy so the frame starts the cycle the core frees up.
      ST_START: begin
        if (!bus.tx_busy) begin
          tx_start_c = 1'b1;
          state_d    = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (bus.tx_done) begin
          if (txb_q.last) begin
            state_d   = ST_GAP;
            grant_d   = '0;
            gap_cnt_d = '0;
            rr_ptr_d  = PW'(rr_next(int'(owner_q), NUM_REQ));
          end else begin
            state_d   = ST_FETCH;
            ready_d   = grant_q;
            tmo_cnt_d = '0;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else                                  gap_cnt_d = gap_cnt_q + GW'(1);
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ready_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
      txb_q     <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      txb_q     <= txb_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.req_ready = ready_q;
  assign bus.tx_data   = txb_q.data;
  assign bus.tx_start  = tx_start_c;
  assign bus.abort     = abort_q;

endmodule
